multdiv_issue_ctrl: RTL and testbench

- Issue/collect stage that sits directly upstream of multdiv, between the execute stage and the multiplier/divider.
- Accepts one MULT or DIV request over a valid/ready handshake and latches the operands.
- Drives multdiv's single-cycle start pulse and holds its operands stable, then waits for data_resultRDY.
- Returns the result, exception and tag over a valid/ready response handshake; a watchdog aborts operations that never complete.

---
 rtl/multdiv_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// Issue/collect stage in front of multdiv: accepts one MULT/DIV request, pulses the
// start control, waits for resultRDY (with a watchdog) and returns the result with its tag.
module multdiv_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] md_operandA,
  output logic [WIDTH-1:0] md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_exception,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             mult_q, mult_d;
  logic             div_q, div_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_exc_q, rsp_exc_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_to_q, rsp_to_d;

  assign req_ready = (state_q == IDLE) & reset;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    tag_d        = tag_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    mult_d       = 1'b0;
    div_d        = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_exc_d    = rsp_exc_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_to_d     = rsp_to_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          opa_d   = req_a;
          opb_d   = req_b;
          op_d    = req_op;
          tag_d   = req_tag;
          // Start pulse is registered here so it is high exactly for the START cycle.
          mult_d  = ~req_op;
          div_d   = req_op;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A result arriving on the last watchdog cycle still counts as a normal completion.
        if (md_resultRDY) begin
          rsp_result_d = md_result;
          rsp_exc_d    = md_exception;
          rsp_tag_d    = tag_q;
          rsp_to_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d = '0;
          rsp_exc_d    = 1'b1;
          rsp_tag_d    = tag_q;
          rsp_to_d     = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= 1'b0;
      tag_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      mult_q       <= 1'b0;
      div_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_exc_q    <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      mult_q       <= mult_d;
      div_q        <= div_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_exc_q    <= rsp_exc_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_to_q     <= rsp_to_d;
    end
  end

  assign md_operandA   = opa_q;
  assign md_operandB   = opb_q;
  assign md_ctrl_MULT  = mult_q;
  assign md_ctrl_DIV   = div_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_exception = rsp_exc_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_timeout   = rsp_to_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl; the bench itself plays the multdiv role.
module tb_multdiv_issue_ctrl;
  localparam int W  = 32;
  localparam int T  = 5;
  localparam int TO = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_op;
  logic [W-1:0] req_a, req_b;
  logic [T-1:0] req_tag;
  logic [W-1:0] md_operandA, md_operandB;
  logic         md_ctrl_MULT, md_ctrl_DIV;
  logic [W-1:0] md_result;
  logic         md_exception, md_resultRDY;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_exception, rsp_timeout, busy;
  logic [T-1:0] rsp_tag;

  int n_chk  = 0;
  int n_pass = 0;
  logic saw_pulse, saw_rsp, opnd_moved, bad;
  logic [W-1:0] exp_a, exp_b;

  multdiv_issue_ctrl #(.WIDTH(W), .TAG_W(T), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_exception(rsp_exception), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (md_ctrl_MULT || md_ctrl_DIV) saw_pulse = 1'b1;
      if (rsp_valid) saw_rsp = 1'b1;
      if (md_operandA !== exp_a || md_operandB !== exp_b) opnd_moved = 1'b1;
    end
  endtask

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] tag);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    exp_a = a; exp_b = b;
    tick();
    req_valid = 1'b0; req_a = '1; req_b = '1; req_tag = '1;
    saw_pulse = 1'b0; saw_rsp = 1'b0; opnd_moved = 1'b0;
  endtask

  task automatic set_rdy(input logic [W-1:0] res, input logic exc);
    md_resultRDY = 1'b1; md_result = res; md_exception = exc;
  endtask

  task automatic clr_rdy();
    md_resultRDY = 1'b0; md_result = 32'hDEADBEEF; md_exception = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b1; req_op = 1'b0; req_a = 32'h1111; req_b = 32'h2222;
    req_tag = 5'd7; rsp_ready = 1'b0; md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
    exp_a = '0; exp_b = '0; saw_pulse = 1'b0; saw_rsp = 1'b0; opnd_moved = 1'b0; bad = 1'b0;

    // Reset held low with a request pending
    for (int i = 0; i < 3; i++) begin
      tick();
      if (req_ready || busy || md_ctrl_MULT || md_ctrl_DIV || rsp_valid) bad = 1'b1;
    end
    chk("rst_quiet", 64'(bad), 64'(0));
    chk("rst_opA", 64'(md_operandA), 64'(0));
    chk("rst_opB", 64'(md_operandB), 64'(0));
    chk("rst_rsp", 64'({rsp_result, rsp_exception, rsp_tag, rsp_timeout}), 64'(0));
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_release_ready", 64'(req_ready), 64'(1));

    // MULT, RDY 33 cycles into WAIT
    issue(1'b0, 32'h00FFFFFF, 32'hFF333334, 5'd3);
    chk("mult_pulse", 64'(md_ctrl_MULT), 64'(1));
    chk("mult_div_low", 64'(md_ctrl_DIV), 64'(0));
    chk("mult_opA", 64'(md_operandA), 64'(32'h00FFFFFF));
    chk("mult_opB", 64'(md_operandB), 64'(32'hFF333334));
    chk("mult_busy_ready", 64'({busy, req_ready}), 64'(2'b10));
    tick();
    chk("mult_pulse_one_cycle", 64'(md_ctrl_MULT), 64'(0));
    idle_ticks(33);
    chk("mult_wait_quiet", 64'({saw_pulse, saw_rsp, opnd_moved}), 64'(0));
    set_rdy(32'h34CCCCCC, 1'b1);
    tick();
    clr_rdy();
    chk("mult_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("mult_rsp_result", 64'(rsp_result), 64'(32'h34CCCCCC));
    chk("mult_rsp_exc_tag_to", 64'({rsp_exception, rsp_tag, rsp_timeout}), 64'({1'b1, 5'd3, 1'b0}));
    release_rsp();
    chk("mult_back_idle", 64'({rsp_valid, busy, req_ready}), 64'(3'b001));
    chk("mult_result_held", 64'(rsp_result), 64'(32'h34CCCCCC));

    // DIV with response back-pressure
    issue(1'b1, 32'd100, 32'd7, 5'd9);
    chk("div_pulse", 64'({md_ctrl_MULT, md_ctrl_DIV}), 64'(2'b01));
    tick();
    idle_ticks(32);
    chk("div_wait_quiet", 64'({saw_pulse, saw_rsp, opnd_moved}), 64'(0));
    set_rdy(32'd14, 1'b0);
    tick();
    clr_rdy();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid || rsp_result !== 32'd14 || rsp_exception || rsp_tag !== 5'd9 ||
          rsp_timeout || req_ready) bad = 1'b1;
      tick();
    end
    chk("div_bp_stable", 64'(bad), 64'(0));
    chk("div_bp_result", 64'(rsp_result), 64'(14));
    release_rsp();
    chk("div_back_idle", 64'({rsp_valid, busy, req_ready}), 64'(3'b001));

    // Watchdog: no RDY ever
    issue(1'b0, 32'd5, 32'd6, 5'd1);
    tick();
    idle_ticks(TO - 1);
    chk("wd_not_early", 64'(saw_rsp), 64'(0));
    tick();
    chk("wd_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wd_rsp", 64'({rsp_result, rsp_exception, rsp_timeout, rsp_tag}),
        64'({32'd0, 1'b1, 1'b1, 5'd1}));
    release_rsp();

    // Watchdog boundary: RDY on the final WAIT cycle wins
    issue(1'b0, 32'd5, 32'd6, 5'd2);
    tick();
    idle_ticks(TO - 1);
    set_rdy(32'h1234, 1'b0);
    tick();
    clr_rdy();
    chk("wd_edge_valid", 64'(rsp_valid), 64'(1));
    chk("wd_edge_rsp", 64'({rsp_result, rsp_exception, rsp_timeout}), 64'({32'h1234, 1'b0, 1'b0}));
    release_rsp();

    // Stale RDY during START
    issue(1'b1, 32'd50, 32'd5, 5'd2);
    md_resultRDY = 1'b1; md_result = 32'h0BAD;
    tick();
    clr_rdy();
    idle_ticks(4);
    chk("stale_ignored", 64'({saw_rsp, busy}), 64'(2'b01));
    set_rdy(32'd10, 1'b0);
    tick();
    clr_rdy();
    chk("stale_later_rsp", 64'({rsp_valid, rsp_result}), 64'({1'b1, 32'd10}));
    release_rsp();

    // Reset in the middle of WAIT
    issue(1'b0, 32'd7, 32'd8, 5'd4);
    tick();
    idle_ticks(9);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_state", 64'({busy, md_ctrl_MULT, md_ctrl_DIV}), 64'(0));
    chk("midrst_opA", 64'(md_operandA), 64'(0));
    saw_rsp = 1'b0; exp_a = '0; exp_b = '0;
    idle_ticks(9);
    set_rdy(32'h77, 1'b0);
    tick();
    clr_rdy();
    idle_ticks(3);
    chk("midrst_no_rsp", 64'({saw_rsp, saw_pulse, busy}), 64'(0));
    issue(1'b0, 32'd3, 32'd4, 5'd6);
    chk("midrst_next_pulse", 64'({md_ctrl_MULT, md_operandA}), 64'({1'b1, 32'd3}));
    tick();
    set_rdy(32'd12, 1'b0);
    tick();
    clr_rdy();
    chk("midrst_next_rsp", 64'({rsp_valid, rsp_result, rsp_tag}), 64'({1'b1, 32'd12, 5'd6}));
    release_rsp();
    chk("final_idle", 64'({busy, req_ready}), 64'(2'b01));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
